bicubic_window_gen: RTL and testbench

Streaming 4x4 window generator that sits directly downstream of the padded-frame BMP pixel source in the bicubic upscaling path. It accepts 24-bit RGB pixels of a padded frame ((HEIGHT+3) x (WIDTH+3), raster order) over a valid/ready handshake. It buffers three previous rows and emits one 4x4 neighbourhood per source pixel, HEIGHT*WIDTH windows per frame, to the bicubic interpolation core.

---
 rtl/bicubic_window_gen_if.sv | 30 +++
 rtl/bicubic_window_gen.sv | 126 ++++++++++++
 tb/tb_bicubic_window_gen.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bicubic_window_gen_if.sv
// Pixel-in / window-out handshake bundle for the bicubic 4x4 window generator.
interface bicubic_window_gen_if #(
  parameter int unsigned WIDTH  = 11,
  parameter int unsigned HEIGHT = 6
);
  localparam int unsigned XW    = $clog2(WIDTH);
  localparam int unsigned YW    = $clog2(HEIGHT);
  localparam int unsigned PIX_W = 24;
  localparam int unsigned WIN_W = 16 * PIX_W;

  logic [PIX_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIN_W-1:0] out_window;
  logic [XW-1:0]    out_x;
  logic [YW-1:0]    out_y;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_window, out_x, out_y, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_window, out_x, out_y, out_last, out_valid
  );
endinterface

// File: rtl/bicubic_window_gen.sv
// Streaming 4x4 window generator over a padded raster frame: three line buffers
// plus a shifting window register, one window emitted per source pixel.
module bicubic_window_gen #(
  parameter int unsigned WIDTH  = 11,
  parameter int unsigned HEIGHT = 6
) (
  input logic                clk,
  input logic                rst,
  bicubic_window_gen_if.slave bus
);
  localparam int unsigned PW    = WIDTH + 3;
  localparam int unsigned PH    = HEIGHT + 3;
  localparam int unsigned PIX_W = 24;
  localparam int unsigned WIN_W = 16 * PIX_W;
  localparam int unsigned CW    = $clog2(PW);
  localparam int unsigned RW    = $clog2(PH);
  localparam int unsigned XW    = $clog2(WIDTH);
  localparam int unsigned YW    = $clog2(HEIGHT);

  logic [CW-1:0]    in_col_q, in_col_d;
  logic [RW-1:0]    in_row_q, in_row_d;
  logic [PIX_W-1:0] lb0_q [PW];
  logic [PIX_W-1:0] lb1_q [PW];
  logic [PIX_W-1:0] lb2_q [PW];
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] out_window_q, out_window_d;
  logic [XW-1:0]    out_x_q, out_x_d;
  logic [YW-1:0]    out_y_q, out_y_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready_c;
  logic             acc_c;
  logic             emit_c;
  logic [PIX_W-1:0] col_c [4];

  assign in_ready_c = ~out_valid_q | bus.out_ready;
  assign acc_c      = bus.in_valid & in_ready_c;
  assign emit_c     = acc_c & (in_row_q >= RW'(3)) & (in_col_q >= CW'(3));

  // Column entering the window, oldest row on top.
  always_comb begin
    col_c[0] = lb2_q[in_col_q];
    col_c[1] = lb1_q[in_col_q];
    col_c[2] = lb0_q[in_col_q];
    col_c[3] = bus.in_data;
  end

  always_comb begin
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    win_d        = win_q;
    out_window_d = out_window_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (acc_c) begin
      if (in_col_q == CW'(PW - 1)) begin
        in_col_d = '0;
        in_row_d = (in_row_q == RW'(PH - 1)) ? '0 : in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end

      for (int ky = 0; ky < 4; ky++) begin
        for (int kx = 0; kx < 3; kx++) begin
          win_d[(4*ky+kx)*PIX_W +: PIX_W] = win_q[(4*ky+kx+1)*PIX_W +: PIX_W];
        end
        win_d[(4*ky+3)*PIX_W +: PIX_W] = col_c[ky];
      end
    end

    // Output registers capture the post-shift window.
    if (emit_c) begin
      out_window_d = win_d;
      out_x_d      = XW'(in_col_q - CW'(3));
      out_y_d      = YW'(in_row_q - RW'(3));
      out_last_d   = (in_row_q == RW'(PH - 1)) && (in_col_q == CW'(PW - 1));
      out_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_col_q     <= '0;
      in_row_q     <= '0;
      win_q        <= '0;
      out_window_q <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      win_q        <= win_d;
      out_window_q <= out_window_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Line buffers are plain storage; stale rows never reach an emitted window.
  always_ff @(posedge clk) begin
    if (acc_c) begin
      lb2_q[in_col_q] <= lb1_q[in_col_q];
      lb1_q[in_col_q] <= lb0_q[in_col_q];
      lb0_q[in_col_q] <= bus.in_data;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_window = out_window_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_bicubic_window_gen.sv
// Randomized-handshake bench for bicubic_window_gen against a frame-level window model.
module tb_bicubic_window_gen;
  localparam int W  = 11;
  localparam int H  = 6;
  localparam int PW = W + 3;
  localparam int PH = H + 3;

  typedef struct packed {
    logic [383:0] win;
    logic [3:0]   x;
    logic [2:0]   y;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [23:0] pix_q[$];
  int          crd_q[$];
  exp_t        exp_q[$];

  bicubic_window_gen_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  bicubic_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Padded pixel (r,c) of a frame is {r+off, c, A5}; window (x,y) element (ky,kx) is pixel (y+ky, x+kx).
  task automatic gen_frame(input int off);
    exp_t e;
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++) begin
        pix_q.push_back({8'(r + off), 8'(c), 8'hA5});
        crd_q.push_back(r * 256 + c);
      end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        for (int ky = 0; ky < 4; ky++)
          for (int kx = 0; kx < 4; kx++)
            e.win[(4*ky+kx)*24 +: 24] = {8'(y + ky + off), 8'(x + kx), 8'hA5};
        e.x    = 4'(x);
        e.y    = 3'(y);
        e.last = (x == W - 1) && (y == H - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic run(input int vprob, input int rprob, input int stall_at);
    int           got = 0;
    int           cyc = 0;
    int           stall_left = 5;
    bit           stalling = 0;
    bit           snapped = 0;
    bit           lat_pend = 0;
    int           lat_x = 0, lat_y = 0, rc;
    logic [383:0] snap_w = '0;
    logic [3:0]   snap_x = '0;
    logic [2:0]   snap_y = '0;
    exp_t         e;
    while ((pix_q.size() > 0 || exp_q.size() > 0) && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.in_valid = (pix_q.size() > 0) && ($urandom_range(99) < vprob);
      bus.in_data  = (pix_q.size() > 0) ? pix_q[0] : 24'h0;
      stalling     = (stall_at >= 0) && (got == stall_at) && bus.out_valid && (stall_left > 0);
      if (stalling) begin
        stall_left--;
        bus.out_ready = 1'b0;
      end else begin
        bus.out_ready = ($urandom_range(99) < rprob);
      end
      @(negedge clk);
      if (lat_pend) begin
        check("lat_valid", 384'(bus.out_valid), 384'(1'b1));
        check("lat_x", 384'(bus.out_x), 384'(lat_x));
        check("lat_y", 384'(bus.out_y), 384'(lat_y));
        lat_pend = 0;
      end
      if (stalling) begin
        check("stall_in_ready", 384'(bus.in_ready), 384'(1'b0));
        if (snapped) begin
          check("stall_window", bus.out_window, snap_w);
          check("stall_x", 384'(bus.out_x), 384'(snap_x));
          check("stall_y", 384'(bus.out_y), 384'(snap_y));
        end else begin
          snap_w  = bus.out_window;
          snap_x  = bus.out_x;
          snap_y  = bus.out_y;
          snapped = 1;
        end
      end else if (rprob == 100) begin
        check("tput_in_ready", 384'(bus.in_ready), 384'(1'b1));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_tests++;
        assert (exp_q.size() != 0)
        else begin
          n_fail++;
          $error("FAIL extra_window observed=x%0d,y%0d expected=none", bus.out_x, bus.out_y);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("window", bus.out_window, e.win);
          check("out_x", 384'(bus.out_x), 384'(e.x));
          check("out_y", 384'(bus.out_y), 384'(e.y));
          check("out_last", 384'(bus.out_last), 384'(e.last));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        void'(pix_q.pop_front());
        rc = crd_q.pop_front();
        if ((rc / 256) >= 3 && (rc % 256) >= 3) begin
          lat_pend = 1;
          lat_x    = (rc % 256) - 3;
          lat_y    = (rc / 256) - 3;
        end
      end
    end
    n_tests++;
    assert (pix_q.size() == 0 && exp_q.size() == 0)
    else begin
      n_fail++;
      $error("FAIL run_timeout observed=pix%0d,win%0d expected=0,0", pix_q.size(), exp_q.size());
    end
    pix_q.delete();
    crd_q.delete();
    exp_q.delete();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 24'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 384'(bus.out_valid), 384'(1'b0));
    check("rst_window", bus.out_window, 384'(0));
    check("rst_in_ready", 384'(bus.in_ready), 384'(1'b1));
    check("rst_x", 384'(bus.out_x), 384'(0));
    check("rst_y", 384'(bus.out_y), 384'(0));
    check("rst_last", 384'(bus.out_last), 384'(1'b0));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_valid", 384'(bus.out_valid), 384'(1'b0));
    end

    // Continuous frame, stalled frame, random gaps/backpressure.
    gen_frame(0);
    run(100, 100, -1);
    gen_frame(0);
    run(100, 100, 20);
    gen_frame(0);
    run(50, 60, -1);

    // Back-to-back frames with distinct row offsets.
    gen_frame(0);
    gen_frame(16);
    run(100, 100, -1);

    // Partial frame of 40 pixels, then reset and a clean frame.
    for (int i = 0; i < 40; i++) begin
      pix_q.push_back({8'(i / PW + 64), 8'(i % PW), 8'h5A});
      crd_q.push_back((i / PW) * 256 + (i % PW));
    end
    run(100, 100, -1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_valid", 384'(bus.out_valid), 384'(1'b0));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    gen_frame(32);
    run(100, 100, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
